// File: rtl/ow_pkg.sv
// ow_pkg: shared 1-Wire definitions for the bus-preparation stage and the ROM reader.
//   Timing constants are in microseconds. Each user scales them by its own CLK_PER_US.
//   CMD_READ_ROM is the Read ROM command byte.
//   ow_state_e lists the sequencer states. The numeric codes are fixed because they
//   appear on the state_dbg port.
`timescale 1ns/1ps
package ow_pkg;

  localparam int T_RSTL = 480;  // reset pulse low time, also the presence window length
  localparam int T_PDS  = 70;   // presence sample point inside the release window
  localparam int T_SLOT = 70;   // write slot length
  localparam int T_LOW1 = 6;    // low time for a '1' write slot
  localparam int T_LOW0 = 60;   // low time for a '0' write slot

  localparam logic [7:0] CMD_READ_ROM = 8'h33;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_WAIT = 3'd2,
    ST_CMD_SLOT = 3'd3,
    ST_READ_ROM = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } ow_state_e;

endpackage

// File: rtl/ow_bit_writer.sv
// ow_bit_writer: drives one 1-Wire write time slot.
//   clk, rst  - clock and asynchronous active-high reset
//   go        - starts a slot on the next edge. It may coincide with slot_done so that
//               slots run back to back.
//   bit_val   - bit to write. It is captured together with go.
//   drive_low - registered request to pull the bus low
//   slot_done - high during the last cycle of the slot
`timescale 1ns/1ps
module ow_bit_writer
  import ow_pkg::*;
#(
  parameter int CLK_PER_US = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic drive_low,
  output logic slot_done
);

  localparam int SLOT_CYC = T_SLOT * CLK_PER_US;
  localparam int CW       = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] SLOT_END = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] LOW1_CYC = CW'(T_LOW1 * CLK_PER_US);
  localparam logic [CW-1:0] LOW0_CYC = CW'(T_LOW0 * CLK_PER_US);

  logic          active;
  logic          bit_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] low_len;
  logic [CW-1:0] cnt_inc;

  assign low_len = bit_q ? LOW1_CYC : LOW0_CYC;
  assign cnt_inc = cnt + CW'(1);

  // drive_low is the registered copy of "the next cycle is still inside the low phase".
  // The bus therefore never depends combinationally on the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      bit_q     <= 1'b0;
      cnt       <= '0;
      drive_low <= 1'b0;
    end else if (go) begin
      active    <= 1'b1;
      bit_q     <= bit_val;
      cnt       <= '0;
      drive_low <= 1'b1;
    end else if (active) begin
      if (cnt == SLOT_END) begin
        active    <= 1'b0;
        drive_low <= 1'b0;
      end else begin
        cnt       <= cnt_inc;
        drive_low <= (cnt_inc < low_len);
      end
    end
  end

  assign slot_done = active && (cnt == SLOT_END);

endmodule

// File: rtl/ow_rom_cmd_init.sv
// ow_rom_cmd_init: prepares the 1-Wire bus for the ROM reader.
//   The block issues a reset pulse and checks for a presence pulse. It then writes CMD
//   LSB-first and hands the bus over to the ROM reader.
//   clk, rst         - clock and asynchronous active-high reset
//   bus              - open-drain line. This block only drives 0 and releases it otherwise.
//   start            - begins a sequence. It is only looked at in IDLE.
//   en_read_rom      - high for the whole READ_ROM state
//   done_reading_rom - ROM reader completion. It is only looked at in READ_ROM.
//   busy             - high in every state except IDLE
//   presence         - presence result of the last reset. A new start clears it.
//   no_device        - sticky flag, set when no presence pulse was seen. A new start clears it.
//   done             - one-cycle pulse when a sequence completes
//   state_dbg        - current state code, using the ow_state_e values
// Hand-off to the ROM reader: en_read_rom stays high until done_reading_rom is seen high
// on a rising edge. en_read_rom drops on the next cycle. The reader owns the bus for as
// long as en_read_rom is high.
`timescale 1ns/1ps
module ow_rom_cmd_init
  import ow_pkg::*;
#(
  parameter int         CLK_PER_US = 1,
  parameter logic [7:0] CMD        = CMD_READ_ROM
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        bus,
  input  logic       start,
  output logic       en_read_rom,
  input  logic       done_reading_rom,
  output logic       busy,
  output logic       presence,
  output logic       no_device,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int RSTL_CYC = T_RSTL * CLK_PER_US;
  localparam int CW       = $clog2(RSTL_CYC + 1);
  localparam logic [CW-1:0] RSTL_END = CW'(RSTL_CYC - 1);
  localparam logic [CW-1:0] PDS_AT   = CW'(T_PDS * CLK_PER_US);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_RST_LOW  = ST_RST_LOW;
  localparam logic [2:0] S_RST_WAIT = ST_RST_WAIT;
  localparam logic [2:0] S_CMD_SLOT = ST_CMD_SLOT;
  localparam logic [2:0] S_READ_ROM = ST_READ_ROM;
  localparam logic [2:0] S_DONE     = ST_DONE;
  localparam logic [2:0] S_ERR      = ST_ERR;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          rst_drive;
  logic          bus_s1, bus_s2;
  logic          bw_go, bw_bit, bw_drive, bw_done;

  // Both drive requests are flops that are cleared asynchronously. Asserting rst
  // therefore releases the line at once, in the middle of a slot if necessary.
  assign bus = (rst_drive || bw_drive) ? 1'b0 : 1'bz;

  // The first slot is launched from the last RST_WAIT cycle. Each later slot is launched
  // from the slot_done cycle of the previous one. This keeps the slots exactly T_SLOT apart.
  always_comb begin
    bw_go  = 1'b0;
    bw_bit = CMD[0];
    if (state == S_RST_WAIT && cnt == RSTL_END && presence) begin
      bw_go = 1'b1;
    end else if (state == S_CMD_SLOT && bw_done && bit_idx != 3'd7) begin
      bw_go  = 1'b1;
      bw_bit = CMD[bit_idx + 3'd1];
    end
  end

  ow_bit_writer #(.CLK_PER_US(CLK_PER_US)) u_bit_writer (
    .clk       (clk),
    .rst       (rst),
    .go        (bw_go),
    .bit_val   (bw_bit),
    .drive_low (bw_drive),
    .slot_done (bw_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      rst_drive <= 1'b0;
      bus_s1    <= 1'b1;
      bus_s2    <= 1'b1;
      presence  <= 1'b0;
      no_device <= 1'b0;
      done      <= 1'b0;
    end else begin
      bus_s1 <= bus;
      bus_s2 <= bus_s1;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            presence  <= 1'b0;
            no_device <= 1'b0;
            cnt       <= '0;
            rst_drive <= 1'b1;
            state     <= S_RST_LOW;
          end
        end
        S_RST_LOW: begin
          if (cnt == RSTL_END) begin
            cnt       <= '0;
            rst_drive <= 1'b0;
            state     <= S_RST_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RST_WAIT: begin
          if (cnt == PDS_AT) presence <= ~bus_s2;
          // The phase has a fixed length. A slave that still holds the line low at
          // this point does not delay the command slots.
          if (cnt == RSTL_END) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= presence ? S_CMD_SLOT : S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CMD_SLOT: begin
          if (bw_done) begin
            if (bit_idx == 3'd7) state <= S_READ_ROM;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        S_READ_ROM: begin
          if (done_reading_rom) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_ERR: begin
          no_device <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign en_read_rom = (state == S_READ_ROM);
  assign state_dbg   = state;

endmodule

// File: tb/tb_ow_rom_cmd_init.sv
// tb_ow_rom_cmd_init: bench for ow_rom_cmd_init with CLK_PER_US=1.
//   Cycle numbering: start is sampled at edge N, and "cycle N+j" is the interval that
//   follows edge N+j-1. The bench samples each cycle at its falling edge.
`timescale 1ns/1ps
module tb_ow_rom_cmd_init;

  localparam int CAP = 1535;  // captured cycles after start, which reach into READ_ROM

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       done_reading_rom = 1'b0;
  wire        bus;
  logic       en_read_rom, busy, presence, no_device, done;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  pullup (bus);

  logic slave_low = 1'b0;
  bit   slave_on  = 1'b0;
  assign bus = slave_low ? 1'b0 : 1'bz;

  ow_rom_cmd_init #(.CLK_PER_US(1), .CMD(8'h33)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .start            (start),
    .en_read_rom      (en_read_rom),
    .done_reading_rom (done_reading_rom),
    .busy             (busy),
    .presence         (presence),
    .no_device        (no_device),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cmd_byte = 8'h33;

  logic cap_bus   [1:CAP];
  logic cap_en    [1:CAP];
  logic cap_busy  [1:CAP];
  logic cap_pres  [1:CAP];
  logic cap_nodev [1:CAP];

  // ---------------- slave model ----------------
  // The slave watches for a long low (the reset pulse). When the line is released it
  // waits a random 15..60 cycles and then pulls low until 140 cycles after the release.
  int low_run   = 0;
  int since_rel = 0;
  int slave_d   = 20;
  bit armed     = 1'b0;

  always @(negedge clk) begin
    if (rst || !slave_on) begin
      slave_low = 1'b0;
      low_run   = 0;
      armed     = 1'b0;
    end else if (armed) begin
      since_rel = since_rel + 1;
      slave_low = (since_rel >= slave_d) && (since_rel < 140);
      if (since_rel >= 140) armed = 1'b0;
    end else if (bus === 1'b0) begin
      low_run = low_run + 1;
    end else begin
      if (low_run >= 400) begin
        armed     = 1'b1;
        since_rel = 0;
        slave_d   = $urandom_range(15, 60);
      end
      low_run = 0;
    end
  end

  // ---------------- reference model ----------------
  // Width of the low phase of slot k, derived from the command bit.
  function automatic int exp_low_width(input int k);
    return cmd_byte[k] ? 6 : 60;
  endfunction

  // ---------------- driver tasks ----------------
  // Pulses start and records the outputs for CAP cycles.
  // In noisy mode start stays high and done_reading_rom toggles randomly while the DUT
  // is still writing slots.
  task automatic run_capture(input bit noisy);
    @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= CAP; j++) begin
      @(negedge clk);
      cap_bus[j]   = bus;
      cap_en[j]    = en_read_rom;
      cap_busy[j]  = busy;
      cap_pres[j]  = presence;
      cap_nodev[j] = no_device;
      if (noisy && j < CAP) begin
        start            = 1'b1;
        done_reading_rom = (j <= 1519) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        start            = 1'b0;
        done_reading_rom = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; done_reading_rom = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus !== 1'b1) begin errors++; $display("FAIL reset_bus: got %b expected 1", bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (en_read_rom !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_read_rom); end
    checks++; if (presence !== 1'b0) begin errors++; $display("FAIL reset_presence: got %b expected 0", presence); end
    checks++; if (no_device !== 1'b0) begin errors++; $display("FAIL reset_no_device: got %b expected 0", no_device); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_sequence(input bit noisy, input int hold);
    int bad;
    int w;
    int base;
    logic [7:0] exp_w;
    slave_on = 1'b1;
    run_capture(noisy);

    bad = 0;
    for (int j = 1; j <= 480; j++) if (cap_bus[j] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_low_window: got %0d high cycles expected 0", bad); end
    checks++; if (cap_bus[481] !== 1'b1) begin errors++; $display("FAIL rst_release: got %b expected 1", cap_bus[481]); end
    checks++; if (cap_pres[1] !== 1'b0) begin errors++; $display("FAIL presence_cleared: got %b expected 0", cap_pres[1]); end
    checks++; if (cap_pres[551] !== 1'b0) begin errors++; $display("FAIL presence_early: got %b expected 0", cap_pres[551]); end
    checks++; if (cap_pres[552] !== 1'b1) begin errors++; $display("FAIL presence_latch: got %b expected 1", cap_pres[552]); end

    for (int k = 0; k < 8; k++) exp_q.push_back(8'(exp_low_width(k)));
    for (int k = 0; k < 8; k++) begin
      base = 961 + 70 * k;
      w = 0;
      while (w < 70 && cap_bus[base + w] === 1'b0) w++;
      exp_w = exp_q.pop_front();
      checks++;
      if (8'(w) !== exp_w || cap_bus[base - 1] !== 1'b1) begin
        errors++;
        $display("FAIL slot%0d_width: got %0d (pre %b) expected %0d (pre 1)", k, w, cap_bus[base - 1], exp_w);
      end
    end

    bad = 0;
    for (int j = 1; j <= 1520; j++) if (cap_en[j] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL en_early: got %0d cycles expected 0", bad); end
    checks++; if (cap_en[1521] !== 1'b1) begin errors++; $display("FAIL en_rise: got %b expected 1", cap_en[1521]); end
    bad = 0;
    for (int j = 1; j <= CAP; j++) if (cap_busy[j] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_span: got %0d idle cycles expected 0", bad); end

    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (en_read_rom !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL read_rom_hold: got %0d bad cycles expected 0", bad); end
    done_reading_rom = 1'b1;
    @(negedge clk);
    done_reading_rom = 1'b0;
    checks++; if (en_read_rom !== 1'b0) begin errors++; $display("FAIL en_fall: got %b expected 0", en_read_rom); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early: got %b expected 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    test_full_sequence(1'b1, $urandom_range(10, 60));
  endtask

  task automatic test_no_device();
    int bad;
    slave_on = 1'b0;
    run_capture(1'b0);
    checks++; if (cap_nodev[961] !== 1'b0) begin errors++; $display("FAIL nodev_early: got %b expected 0", cap_nodev[961]); end
    checks++; if (cap_nodev[962] !== 1'b1) begin errors++; $display("FAIL nodev_rise: got %b expected 1", cap_nodev[962]); end
    checks++; if (cap_busy[961] !== 1'b1) begin errors++; $display("FAIL nodev_busy961: got %b expected 1", cap_busy[961]); end
    checks++; if (cap_busy[962] !== 1'b0) begin errors++; $display("FAIL nodev_busy962: got %b expected 0", cap_busy[962]); end
    bad = 0;
    for (int j = 1; j <= CAP; j++) if (cap_en[j] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nodev_en: got %0d cycles expected 0", bad); end
    bad = 0;
    for (int j = 962; j <= CAP; j++) if (cap_busy[j] !== 1'b0 || cap_nodev[j] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL nodev_after: got %0d bad cycles expected 0", bad); end
    checks++; if (cap_pres[CAP] !== 1'b0) begin errors++; $display("FAIL nodev_presence: got %b expected 0", cap_pres[CAP]); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (no_device !== 1'b0) begin errors++; $display("FAIL nodev_clear: got %b expected 0", no_device); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nodev_restart: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rst_mid_slot();
    int target;
    target = 961 + 70 * 3 + 20;
    slave_on = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= target; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (bus !== 1'b0) begin errors++; $display("FAIL slot3_driving: got %b expected 0", bus); end
    rst = 1'b1;
    #1;
    checks++; if (bus !== 1'b1) begin errors++; $display("FAIL rst_mid_bus: got %b expected 1", bus); end
    checks++; if (busy !== 1'b0 || en_read_rom !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got busy=%b en=%b done=%b expected 0/0/0", busy, en_read_rom, done);
    end
    checks++; if (presence !== 1'b0 || no_device !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: got presence=%b no_device=%b expected 0/0", presence, no_device);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet: got bus=%b busy=%b expected 1/0", bus, busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_sequence(1'b0, 5000);
    test_back_to_back();
    test_no_device();
    test_rst_mid_slot();
    test_full_sequence(1'b0, $urandom_range(5, 40));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ow_rom_cmd_init.md
# ow_rom_cmd_init

Upstream 1-Wire master stage that prepares the bus for the ROM reader. On `start` it issues the reset pulse, checks for a presence pulse, and shifts out the Read ROM command byte (0x33) LSB-first as write time slots. It then hands the bus to the ROM reader through `en_read_rom`, holds that enable until `done_reading_rom` returns, and reports completion or absence of a device.

## Interface
Parameters:
- `CLK_PER_US`, 1 — clock cycles per microsecond; all bus timings scale by it.
- `CMD`, 8'h33 — command byte sent after presence (Read ROM).

Ports:
- `clk`  in  1 — single clock; all logic on rising edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `bus`  inout  1 — open-drain 1-Wire line. Driven only with 0; released otherwise (`1'bz`).
- `start`  in  1 — begin a sequence; sampled only in IDLE.
- `en_read_rom`  out  1 — enable to the ROM reader; high for the whole READ_ROM state.
- `done_reading_rom`  in  1 — completion from the ROM reader.
- `busy`  out  1 — high in every state except IDLE.
- `presence`  out  1 — latched presence result of the last reset; cleared on `start`.
- `no_device`  out  1 — sticky error when no presence was seen; cleared on `start`.
- `done`  out  1 — one-cycle pulse when a sequence completes successfully.

## Operation
- Reset values: bus released, `en_read_rom`=0, `busy`=0, `presence`=0, `no_device`=0, `done`=0, state IDLE, counters 0.
- `bus` input is passed through a 2-flop synchronizer before any sampling.
- States and transitions:
  - IDLE: on `start`, clear `presence` and `no_device`, then go to RST_LOW.
  - RST_LOW: drive bus 0 for T_RSTL cycles, then go to RST_WAIT.
  - RST_WAIT: bus released for T_RSTL cycles. At cycle T_PDS of this phase, latch `presence` = (synced bus == 0). At the end of the phase, go to CMD_SLOT if presence was seen, else go to ERR.
  - CMD_SLOT: 8 slots of T_SLOT cycles each, bit index 0..7 (LSB first). For bit=1, drive 0 for T_LOW1 cycles, then release. For bit=0, drive 0 for T_LOW0 cycles, then release. After slot 7, go to READ_ROM.
  - READ_ROM: `en_read_rom`=1 and bus released by this block. On `done_reading_rom`=1, drop `en_read_rom` next cycle and go to DONE.
  - DONE: pulse `done` for one cycle, then go to IDLE.
  - ERR: set `no_device`=1, then go to IDLE.
- Timing constants, in µs × `CLK_PER_US`: T_RSTL=480, T_PDS=70, T_SLOT=70, T_LOW1=6, T_LOW0=60.
- Boundary conditions:
  - `start` while busy is ignored.
  - `done_reading_rom` outside READ_ROM is ignored.
  - Slave holding bus low past RST_WAIT has no effect on sequencing.
  - `rst` mid-operation releases the bus combinationally and returns all outputs to reset values; no partial slot is completed.
- The counter must hold 480×`CLK_PER_US`. The bit index is 3 bits and does not wrap past 7.

## Timing
Values below use `CLK_PER_US`=1 and take `start` high at edge N.
- RST_LOW begins at N+1 and the bus is low for cycles N+1..N+480.
- Presence sample at N+481+70.
- Slot k begins at N+961+70k.
- `en_read_rom` rises at N+1521.
- `done` pulses 2 cycles after the edge that samples `done_reading_rom`=1.
- No presence: `no_device` rises at N+962, `busy` falls at N+962.
- Bus drive decisions are registered; no combinational path from `start` to `bus`.

## Structure
- Package `ow_pkg`:
  - timing constants T_RSTL, T_PDS, T_SLOT, T_LOW1, T_LOW0;
  - `CMD_READ_ROM`=8'h33;
  - state enum.
  The ROM reader shares these constants.
- One sub-module, `ow_bit_writer`: given a bit and a go pulse, it drives one write slot and returns a slot-done pulse. Instantiated once and reused for all 8 bits.

## Test plan
- Slave model pulls bus low 20–140 µs after reset release; `start` → bus low 480 cycles, `presence`=1, `en_read_rom` at N+1521.
- Same run, monitor slot low widths → exactly 6,6,60,60,6,6,60,60 cycles (0x33 LSB-first), each slot 70 cycles.
- No slave → `no_device`=1 at N+962, `en_read_rom` never asserted, `busy`=0 afterwards. A later `start` clears `no_device`.
- In READ_ROM, hold `done_reading_rom` low 5000 cycles, then pulse it → `en_read_rom` held until then, falls the next cycle, followed by one `done` pulse.
- Assert `rst` during slot 3 → bus released immediately, all outputs at reset values. A fresh `start` reruns the full sequence.
- `start` asserted every cycle during busy and `done_reading_rom` pulsed during CMD_SLOT → no restart, no early exit.
